// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine phase sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wm_pkg;

    localparam int TW_DEF   = 5;
    localparam int TOTW_DEF = 8;

    // Encodings are visible on the phase output, so they are fixed explicitly.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_DONE  = 3'd4
    } phase_t;

    // First phase strictly after 'cur' whose duration is nonzero, or DONE.
    // nz = {spin_nz, rinse_nz, wash_nz}. From IDLE the search starts at WASH.
    function automatic phase_t next_phase(input phase_t cur, input logic [2:0] nz);
        phase_t res;
        res = PH_DONE;
        case (cur)
            PH_IDLE: begin
                if (nz[0])      res = PH_WASH;
                else if (nz[1]) res = PH_RINSE;
                else if (nz[2]) res = PH_SPIN;
            end
            PH_WASH: begin
                if (nz[1])      res = PH_RINSE;
                else if (nz[2]) res = PH_SPIN;
            end
            PH_RINSE: begin
                if (nz[2])      res = PH_SPIN;
            end
            default: res = PH_DONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wm_cycle_sequencer_if.sv
// Bundle of the sequencer's command inputs and status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; commands are levels/pulses, status is always valid.
// master: drives tick/start/pause/abort and durations, reads status.
// slave:  the sequencer itself.
interface wm_cycle_sequencer_if
    import wm_pkg::*;
#(
    parameter int TW   = TW_DEF,
    parameter int TOTW = TOTW_DEF
);
    logic            tick;
    logic            start;
    logic            pause;
    logic            abort;
    logic [TW-1:0]   wash_time;
    logic [TW-1:0]   rinse_time;
    logic [TW-1:0]   spin_time;
    logic [2:0]      phase;
    logic [TW-1:0]   phase_left;
    logic [TOTW-1:0] remaining;
    logic            busy;
    logic            motor_en;
    logic            drain_en;
    logic            done;

    modport master (
        output tick, start, pause, abort, wash_time, rinse_time, spin_time,
        input  phase, phase_left, remaining, busy, motor_en, drain_en, done
    );

    modport slave (
        input  tick, start, pause, abort, wash_time, rinse_time, spin_time,
        output phase, phase_left, remaining, busy, motor_en, drain_en, done
    );
endinterface

// File: rtl/wm_phase_timer.sv
// Loadable down-counter holding the ticks left in the current phase.
// Latency: load/clear/decrement visible one edge later; zero_next is a decode of the count.
// Backpressure: none; clr > load > dec, decrement saturates at zero.
// Ports: clk, rst_n, clr, load, load_val, dec in; count, zero_next out.
module wm_phase_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic [TW-1:0] count,
    output logic          zero_next
);
    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - TW'(1);
    end

    assign count     = cnt;
    // The next decrement ends the phase.
    assign zero_next = (cnt == TW'(1));
endmodule

// File: rtl/wm_cycle_sequencer.sv
// Wash/rinse/spin phase sequencer with per-phase and total countdowns.
// Latency: start, tick and abort take effect on the next clk edge; outputs are register decodes.
// Backpressure: none; start is ignored outside IDLE, pause freezes counters, abort wins over all.
// Ports: clk, rst_n, bus (slave: commands/durations in, phase/counters/enables out).
module wm_cycle_sequencer
    import wm_pkg::*;
#(
    parameter int TW   = TW_DEF,
    parameter int TOTW = TOTW_DEF   // must hold 3*(2^TW-1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wm_cycle_sequencer_if.slave  bus
);
    phase_t          state, nxt;
    logic [TW-1:0]   wash_q, rinse_q, spin_q;
    logic [TOTW-1:0] rem;
    logic            active, tick_eff, zero_next;
    logic            tmr_clr, tmr_load, rem_load, latch;
    logic [TW-1:0]   tmr_load_val, phase_left;

    function automatic logic [TW-1:0] sel_dur(input phase_t ph, input logic [TW-1:0] w,
                                              input logic [TW-1:0] r, input logic [TW-1:0] s);
        logic [TW-1:0] d;
        d = '0;
        case (ph)
            PH_WASH:  d = w;
            PH_RINSE: d = r;
            PH_SPIN:  d = s;
            default:  d = '0;
        endcase
        return d;
    endfunction

    assign active   = (state == PH_WASH) || (state == PH_RINSE) || (state == PH_SPIN);
    assign tick_eff = active && bus.tick && !bus.pause;

    always_comb begin
        nxt          = state;
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        rem_load     = 1'b0;
        latch        = 1'b0;
        case (state)
            PH_IDLE: begin
                if (bus.start) begin
                    // Route from the live inputs: the latched copies are not valid yet.
                    nxt          = next_phase(PH_IDLE, {bus.spin_time != '0,
                                                        bus.rinse_time != '0,
                                                        bus.wash_time != '0});
                    tmr_load     = 1'b1;
                    tmr_load_val = sel_dur(nxt, bus.wash_time, bus.rinse_time, bus.spin_time);
                    rem_load     = 1'b1;
                    latch        = 1'b1;
                end
            end
            PH_WASH, PH_RINSE, PH_SPIN: begin
                // Final tick of a phase advances on the same edge; the load
                // overrides the decrement in the timer.
                if (tick_eff && zero_next) begin
                    nxt          = next_phase(state, {spin_q != '0, rinse_q != '0, wash_q != '0});
                    tmr_load     = 1'b1;
                    tmr_load_val = sel_dur(nxt, wash_q, rinse_q, spin_q);
                end
            end
            default: nxt = PH_IDLE;   // DONE is a single cycle
        endcase
        if (bus.abort) begin
            nxt      = PH_IDLE;
            tmr_clr  = 1'b1;
            tmr_load = 1'b0;
            rem_load = 1'b0;
            latch    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PH_IDLE;
            wash_q  <= '0;
            rinse_q <= '0;
            spin_q  <= '0;
            rem     <= '0;
        end else begin
            state <= nxt;
            if (latch) begin
                wash_q  <= bus.wash_time;
                rinse_q <= bus.rinse_time;
                spin_q  <= bus.spin_time;
            end
            if (tmr_clr)
                rem <= '0;
            else if (rem_load)
                rem <= TOTW'(bus.wash_time) + TOTW'(bus.rinse_time) + TOTW'(bus.spin_time);
            else if (tick_eff && rem != '0)
                rem <= rem - TOTW'(1);
        end
    end

    wm_phase_timer #(.TW(TW)) u_phase_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tmr_clr),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .dec       (tick_eff),
        .count     (phase_left),
        .zero_next (zero_next)
    );

    assign bus.phase      = state;
    assign bus.phase_left = phase_left;
    assign bus.remaining  = rem;
    assign bus.busy       = active;
    assign bus.motor_en   = active;
    assign bus.drain_en   = (state == PH_SPIN);
    assign bus.done       = (state == PH_DONE);
endmodule
